// File: rtl/mul_fsm_pkg.sv
// Shared definitions for the iterative shift-add multiply-accumulate engine.
//   state_e    : FSM state encoding (IDLE, CALC, DONE)
//   cnt_width  : bit width of the multiplier-bit counter for a given operand width
package mul_fsm_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } state_e;

   // Counter must index every multiplier bit; never narrower than one bit.
   function automatic int unsigned cnt_width(input int unsigned dw);
      return (dw > 1) ? $clog2(dw) : 1;
   endfunction

endpackage

// File: rtl/mul_fsm.sv
// Iterative shift-add multiply-accumulate: product = multiplicand * multiplier + addend,
// one multiplier bit per clock. Fixed latency, data-independent.
// Ports:
//   clk          : clock, rising edge
//   rstn         : synchronous active-low reset
//   en           : request; accepted when en=1 and ready=1
//   ready        : idle and able to accept (registered)
//   multiplicand : operand A, unsigned, sampled at accept
//   multiplier   : operand B, unsigned, sampled at accept
//   addend       : operand C, unsigned, zero-extended, sampled at accept
//   product      : A*B+C, registered, held until the next result
//   vld_out      : one-cycle pulse marking product valid (registered)
module mul_fsm
   import mul_fsm_pkg::*;
#(
   parameter int unsigned DATAWIDTH = 16
) (
   input  logic                   clk,
   input  logic                   rstn,
   input  logic                   en,
   output logic                   ready,
   input  logic [DATAWIDTH-1:0]   multiplicand,
   input  logic [DATAWIDTH-1:0]   multiplier,
   input  logic [DATAWIDTH-1:0]   addend,
   output logic [2*DATAWIDTH-1:0] product,
   output logic                   vld_out
);

   localparam int unsigned PW = 2 * DATAWIDTH;
   localparam int unsigned CW = cnt_width(DATAWIDTH);

   state_e               state_q, state_d;
   logic [DATAWIDTH-1:0] a_q, a_d;
   logic [DATAWIDTH-1:0] b_q, b_d;
   logic [PW-1:0]        acc_q, acc_d;
   logic [PW-1:0]        product_q, product_d;
   logic [CW-1:0]        cnt_q, cnt_d;
   logic                 ready_q, ready_d;
   logic                 vld_q, vld_d;
   logic [PW-1:0]        acc_step;
   logic                 last_bit;

   // One partial-product step: add the shifted multiplicand when the current multiplier bit is set.
   always_comb begin
      acc_step = acc_q;
      if (b_q[cnt_q]) begin
         acc_step = acc_q + (PW'(a_q) << cnt_q);
      end
   end

   assign last_bit = (cnt_q == CW'(DATAWIDTH - 1));

   // Next-state, datapath and output decode.
   always_comb begin
      state_d   = state_q;
      a_d       = a_q;
      b_d       = b_q;
      acc_d     = acc_q;
      cnt_d     = cnt_q;
      product_d = product_q;

      case (state_q)
         IDLE: begin
            if (en) begin
               state_d = CALC;
               a_d     = multiplicand;
               b_d     = multiplier;
               acc_d   = PW'(addend);
               cnt_d   = '0;
            end
         end
         CALC: begin
            acc_d = acc_step;
            cnt_d = cnt_q + CW'(1);
            if (last_bit) begin
               // Final step result goes straight to the output register.
               state_d   = DONE;
               product_d = acc_step;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      // Handshake outputs are registered from the next state.
      ready_d = (state_d == IDLE);
      vld_d   = (state_d == DONE);
   end

   // State and datapath registers.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         state_q   <= IDLE;
         a_q       <= '0;
         b_q       <= '0;
         acc_q     <= '0;
         cnt_q     <= '0;
         product_q <= '0;
         ready_q   <= 1'b1;
         vld_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         a_q       <= a_d;
         b_q       <= b_d;
         acc_q     <= acc_d;
         cnt_q     <= cnt_d;
         product_q <= product_d;
         ready_q   <= ready_d;
         vld_q     <= vld_d;
      end
   end

   assign ready   = ready_q;
   assign vld_out = vld_q;
   assign product = product_q;

endmodule
